dram_arbiter: RTL and testbench
===============================

# dram_arbiter

Two-port arbiter that shares the single-port 64K×8 data RAM between the processor core (port 0) and the image loader/unloader (port 1). It accepts one access per cycle from the selected port and drives the RAM with registered commands. It tracks outstanding reads through a two-stage pipeline and returns read data to the issuing port. A bounded lock lets one port hold the RAM for back-to-back pixel accesses.

## Interface

**Parameters**
- `ADDR_W`, 16: RAM address width.
- `DATA_W`, 8: pixel/data width.
- `MAX_LOCK`, 16: maximum consecutive locked grants before a forced hand-over; range 1–255.

**Ports**
- `clk` in 1: single clock. One clock; reset is asynchronous and active-high.
- `rst` in 1: asynchronous, active-high reset.
- `req0`, `req1` in 1: access request.
- `we0`, `we1` in 1: 1 = write, 0 = read; valid with `req`.
- `lock0`, `lock1` in 1: request to keep ownership after this access.
- `addr0`, `addr1` in ADDR_W: access address.
- `wdata0`, `wdata1` in DATA_W: write data.
- `gnt0`, `gnt1` out 1: combinational; request accepted at next rising edge.
- `rvalid0`, `rvalid1` out 1: read data valid this cycle.
- `rdata0`, `rdata1` out DATA_W: read data; equal to `mem_dout` when `rvalid` is high, 0 otherwise.
- `mem_addr` out ADDR_W: registered RAM address.
- `mem_read`, `mem_write` out 1: registered RAM strobes; never both high.
- `mem_din` out DATA_W: registered RAM write data.
- `mem_dout` in DATA_W: RAM registered read data.

## Operation

- **Ownership FSM:** states FREE, OWN0, OWN1.
- **FREE:**
  - Only one port requesting: that port is granted.
  - Both requesting: the port not served last is granted. The `last` register resets to 1, so port 0 wins the first tie.
- **Entering ownership:** an accepted request with its `lock` high moves the FSM to OWNx and loads `lock_cnt` = 1.
- **OWNx:**
  - Port x is granted whenever `req`x is high; the other port is held off.
  - Each accepted locked access increments `lock_cnt`.
  - Return to FREE when any of these holds:
    - an access is accepted with `lock`x low;
    - `req`x is low;
    - `lock_cnt` = MAX_LOCK and the other port is requesting (forced release). `last` = x, so the other port wins the next tie.
- **Grant rule:** at most one `gnt` per cycle. A port may change `addr`/`we`/`wdata` only after the edge where `req`&`gnt` was high.
- **Command issue:** on an accepted edge, `mem_addr`, `mem_din`, `mem_read` = !we and `mem_write` = we are registered from the granted port. With no acceptance, `mem_read` = `mem_write` = 0; `mem_addr`/`mem_din` hold.
- **Read tracking:** the pipeline records {valid, port id} in stage 1 at issue and shifts it to stage 2 one edge later. Stage 2 valid with port x drives `rvalid`x.
- **Writes:** return no response.

## Timing

- `gnt` is combinational from `req`, FSM state and `last`. No request→grant register delay.
- Acceptance at edge E0 → `mem_read`/`mem_write` high in cycle E0–E1 → RAM captures at E1 → `rvalid`/`rdata` in cycle E1–E2. Read latency is 2 cycles from acceptance.
- Full throughput: one accepted access per cycle. Reads return in order.
- Write followed by a read of the same address on consecutive cycles returns the new data, because the RAM does write-then-read on separate edges.
- **Reset (asynchronous, any time):**
  - FSM = FREE, `last` = 1, `lock_cnt` = 0, pipeline cleared.
  - All `mem_*` outputs = 0; all `rvalid`/`rdata` = 0.
  - In-flight reads are dropped with no `rvalid`.
- **MAX_LOCK = 1:** a lock never persists past one access while the other port requests.
- `lock_cnt` saturates at MAX_LOCK while no other requester is present.

## Structure

- **Shared package `dram_pkg`:**
  - `ADDR_W`, `DATA_W` defaults;
  - port-id constants `PORT_CPU` = 0, `PORT_LDR` = 1;
  - FSM state encoding: FREE = 2'b00, OWN0 = 2'b01, OWN1 = 2'b10.
- **Sub-module `rr_arb2`:** combinational two-input round-robin selector taking {req0, req1, last} and producing a one-hot grant. It is used only in FREE.
- **Top level:** FSM, lock counter, command registers and the read-tracking pipeline stay in `dram_arbiter`.

## Test plan

1. Reset, then `req0` read addr 0x0010 (RAM holds 0x5A) → `gnt0` same cycle, `mem_read` = 1 with `mem_addr` = 0x0010 next cycle, `rvalid0` = 1 with `rdata0` = 0x5A two cycles after acceptance.
2. `req0` and `req1` held high, no lock, 6 cycles → grants alternate 0,1,0,1,0,1; `gnt0` and `gnt1` never both high.
3. Port 1 writes 0xA5 to 0x8000 and port 0 reads 0x8000 on the next cycle → `rvalid0` with `rdata0` = 0xA5.
4. MAX_LOCK = 4, port 0 holds `lock0`, `req0` continuously, `req1` high → four consecutive `gnt0`, then `gnt1`, then port 0 again.
5. Assert `rst` one cycle after a read acceptance → no `rvalid`, all `mem_*` = 0, and the next tie grants port 0.
6. Back-to-back reads 0x0001, 0x0002, 0x0003 from port 1 → `rvalid1` on three consecutive cycles with data in address order.

Source files
------------

// File: rtl/dram_pkg.sv
// Shared definitions for the data-RAM arbiter: default widths, port ids and
// ownership state encoding.
package dram_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  typedef enum logic [1:0] {
    FREE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } own_state_e;

endpackage

// File: rtl/dram_arbiter_rr_arb2.sv
// Two-input round-robin selector; on a tie the port not served last wins.
module rr_arb2 (
  input  logic       req0,
  input  logic       req1,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req0 && (!req1 || last)) gnt = 2'b01;
    else if (req1)               gnt = 2'b10;
  end

endmodule

// File: rtl/dram_arbiter.sv
// Two-port arbiter for the single-port data RAM: ownership FSM with bounded
// lock, registered RAM commands and a two-stage read-return pipeline.
//
// state | meaning
// FREE  | no owner; round-robin between requesters
// OWN0  | port 0 holds the RAM under lock
// OWN1  | port 1 holds the RAM under lock
module dram_arbiter #(
  parameter int ADDR_W   = dram_pkg::ADDR_W,
  parameter int DATA_W   = dram_pkg::DATA_W,
  parameter int MAX_LOCK = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  import dram_pkg::*;

  localparam logic [7:0] LOCK_MAX = 8'(MAX_LOCK);

  own_state_e state, state_nxt;
  logic [7:0] lock_cnt, cnt_nxt;
  logic       last;
  logic [1:0] arb_gnt;
  logic       acc, acc_port, acc_lock, acc_we;
  logic       s1_valid, s1_port, s2_valid, s2_port;

  rr_arb2 u_rr (
    .req0 (req0),
    .req1 (req1),
    .last (last),
    .gnt  (arb_gnt)
  );

  // On a forced release the waiting port is handed the RAM in the same
  // cycle, so the hand-over costs no idle slot.
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    state_nxt = state;
    cnt_nxt   = lock_cnt;
    case (state)
      FREE: begin
        gnt0 = arb_gnt[0];
        gnt1 = arb_gnt[1];
      end
      OWN0: begin
        if (lock_cnt == LOCK_MAX && req1) gnt1 = 1'b1;
        else                              gnt0 = req0;
      end
      OWN1: begin
        if (lock_cnt == LOCK_MAX && req0) gnt0 = 1'b1;
        else                              gnt1 = req1;
      end
      default: ;
    endcase

    acc      = gnt0 | gnt1;
    acc_port = gnt1;
    acc_lock = gnt1 ? lock1 : lock0;
    acc_we   = gnt1 ? we1 : we0;

    if (acc) begin
      if (!acc_lock) begin
        state_nxt = FREE;
        cnt_nxt   = 8'd0;
      end else if ((acc_port == PORT_LDR && state == OWN1) ||
                   (acc_port == PORT_CPU && state == OWN0)) begin
        if (lock_cnt < LOCK_MAX) cnt_nxt = lock_cnt + 8'd1;
      end else begin
        state_nxt = (acc_port == PORT_LDR) ? OWN1 : OWN0;
        cnt_nxt   = 8'd1;
      end
    end else if (state != FREE) begin
      state_nxt = FREE;
      cnt_nxt   = 8'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FREE;
      lock_cnt <= 8'd0;
      last     <= PORT_LDR;
    end else begin
      state    <= state_nxt;
      lock_cnt <= cnt_nxt;
      if (acc) last <= acc_port;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr  <= '0;
      mem_din   <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end else begin
      mem_read  <= acc & ~acc_we;
      mem_write <= acc & acc_we;
      if (acc) begin
        mem_addr <= gnt1 ? addr1 : addr0;
        mem_din  <= gnt1 ? wdata1 : wdata0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_port  <= 1'b0;
      s2_valid <= 1'b0;
      s2_port  <= 1'b0;
    end else begin
      s1_valid <= acc & ~acc_we;
      s1_port  <= acc_port;
      s2_valid <= s1_valid;
      s2_port  <= s1_port;
    end
  end

  assign rvalid0 = s2_valid && (s2_port == PORT_CPU);
  assign rvalid1 = s2_valid && (s2_port == PORT_LDR);
  assign rdata0  = rvalid0 ? mem_dout : '0;
  assign rdata1  = rvalid1 ? mem_dout : '0;

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter with a registered-read RAM model.
module tb_dram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1, lock0, lock1;
  logic [15:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0]  rdata0, rdata1;
  logic [15:0] mem_addr;
  logic        mem_read, mem_write;
  logic [7:0]  mem_din, mem_dout;

  logic [7:0]  ram [0:65535];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  dram_arbiter #(.ADDR_W(16), .DATA_W(8), .MAX_LOCK(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always @(posedge clk) begin
    if (mem_write) ram[mem_addr] <= mem_din;
    if (mem_read)  mem_dout <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    step();
    rst = 0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[16'h0010] = 8'h5A;
    ram[16'h0001] = 8'h11;
    ram[16'h0002] = 8'h22;
    ram[16'h0003] = 8'h33;
    mem_dout = 8'h00;
    idle();
    rst = 1;
    #12;
    chk("rst_mem_read", {31'b0, mem_read}, 0);
    chk("rst_mem_addr", {16'b0, mem_addr}, 0);
    chk("rst_rvalid", {30'b0, rvalid1, rvalid0}, 0);
    step();
    rst = 0;

    // single read from port 0
    req0 = 1; we0 = 0; addr0 = 16'h0010;
    #1;
    chk("t1_gnt", {30'b0, gnt1, gnt0}, 32'h1);
    step();
    req0 = 0;
    chk("t1_mem_read", {30'b0, mem_write, mem_read}, 32'h1);
    chk("t1_mem_addr", {16'b0, mem_addr}, 32'h0010);
    chk("t1_rvalid_early", {31'b0, rvalid0}, 0);
    step();
    chk("t1_rvalid", {31'b0, rvalid0}, 1);
    chk("t1_rdata", {24'b0, rdata0}, 32'h5A);
    step();
    chk("t1_rvalid_end", {31'b0, rvalid0}, 0);
    chk("t1_rdata_zero", {24'b0, rdata0}, 0);

    // unlocked contention alternates starting with port 0
    do_reset();
    req0 = 1; req1 = 1; addr0 = 16'h0100; addr1 = 16'h0200;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("t2_gnt", {30'b0, gnt1, gnt0}, (i % 2 == 0) ? 32'h1 : 32'h2);
      step();
    end
    idle();
    step(); step();

    // write from port 1 then read-after-write from port 0
    do_reset();
    req1 = 1; we1 = 1; addr1 = 16'h8000; wdata1 = 8'hA5;
    #1;
    chk("t3_gnt_wr", {30'b0, gnt1, gnt0}, 32'h2);
    step();
    req1 = 0; we1 = 0;
    req0 = 1; we0 = 0; addr0 = 16'h8000;
    chk("t3_mem_write", {30'b0, mem_write, mem_read}, 32'h2);
    chk("t3_mem_din", {24'b0, mem_din}, 32'hA5);
    #1;
    chk("t3_gnt_rd", {30'b0, gnt1, gnt0}, 32'h1);
    step();
    req0 = 0;
    chk("t3_no_wr_resp", {30'b0, rvalid1, rvalid0}, 0);
    step();
    chk("t3_rvalid", {30'b0, rvalid1, rvalid0}, 32'h1);
    chk("t3_rdata", {24'b0, rdata0}, 32'hA5);

    // bounded lock with MAX_LOCK = 4
    do_reset();
    req0 = 1; lock0 = 1; req1 = 1; lock1 = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t4_lock_gnt0", {30'b0, gnt1, gnt0}, 32'h1);
      step();
    end
    #1;
    chk("t4_handover", {30'b0, gnt1, gnt0}, 32'h2);
    step();
    #1;
    chk("t4_back_to_0", {30'b0, gnt1, gnt0}, 32'h1);
    idle();
    step(); step(); step();

    // reset while a read is in flight
    do_reset();
    req0 = 1; addr0 = 16'h0010;
    step();
    req0 = 0;
    rst = 1;
    #1;
    chk("t5_mem_zero", {mem_din, mem_addr, 6'b0, mem_write, mem_read}, 0);
    chk("t5_rvalid_rst", {30'b0, rvalid1, rvalid0}, 0);
    step();
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      chk("t5_no_rvalid", {30'b0, rvalid1, rvalid0}, 0);
      step();
    end
    req0 = 1; req1 = 1;
    #1;
    chk("t5_tie_port0", {30'b0, gnt1, gnt0}, 32'h1);
    idle();
    step(); step(); step();

    // back-to-back reads from port 1
    do_reset();
    req1 = 1; we1 = 0; addr1 = 16'h0001;
    step();
    addr1 = 16'h0002;
    step();
    chk("t6_rv_a", {31'b0, rvalid1}, 1);
    chk("t6_rd_a", {24'b0, rdata1}, 32'h11);
    addr1 = 16'h0003;
    step();
    req1 = 0;
    chk("t6_rv_b", {31'b0, rvalid1}, 1);
    chk("t6_rd_b", {24'b0, rdata1}, 32'h22);
    step();
    chk("t6_rv_c", {31'b0, rvalid1}, 1);
    chk("t6_rd_c", {24'b0, rdata1}, 32'h33);
    step();
    chk("t6_rv_end", {30'b0, rvalid1, rvalid0}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
